// File: rtl/edge_detector_if.sv
// Pixel-stream bus for the edge detector: upstream pixel/index/line inputs and
// registered edge/line-completion results.
interface edge_detector_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IDX_W = 15
);
  logic             enb;
  logic [PIX_W-1:0] pixIn;
  logic [IDX_W-1:0] idxIn;
  logic             lineReset;
  logic [PIX_W-1:0] threshold;
  logic             edgeValid;
  logic [IDX_W-1:0] edgeIdx;
  logic [PIX_W-1:0] edgeMag;
  logic             lineDone;
  logic [7:0]       lineEdges;

  modport master (
    output enb, pixIn, idxIn, lineReset, threshold,
    input  edgeValid, edgeIdx, edgeMag, lineDone, lineEdges
  );

  modport slave (
    input  enb, pixIn, idxIn, lineReset, threshold,
    output edgeValid, edgeIdx, edgeMag, lineDone, lineEdges
  );
endinterface

// File: rtl/edge_detector.sv
// Horizontal edge detector: flags neighbouring-pixel differences above a threshold
// and reports a per-line edge count at each line boundary.
module edge_detector #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned IDX_W    = 15,
  parameter int unsigned LINE_LEN = 150
) (
  input  logic             clk,
  input  logic             resetIn,
  edge_detector_if.slave   bus
);

  localparam int unsigned CNT_W  = $clog2(LINE_LEN + 1);
  localparam int unsigned EDGE_W = 8;
  localparam logic [EDGE_W-1:0] EDGE_MAX = '1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state,     stateD;
  logic [PIX_W-1:0]  prev,      prevD;
  logic [CNT_W-1:0]  pixCnt,    pixCntD;
  logic [EDGE_W-1:0] edgeCnt,   edgeCntD;
  logic              edgeValid, edgeValidD;
  logic [IDX_W-1:0]  edgeIdx,   edgeIdxD;
  logic [PIX_W-1:0]  edgeMag,   edgeMagD;
  logic              lineDone,  lineDoneD;
  logic [EDGE_W-1:0] lineEdges, lineEdgesD;

  logic [PIX_W:0]    sub;
  logic [PIX_W-1:0]  diff;
  logic              lineStart;

  // Absolute difference via a one-bit-wider subtraction; the top bit is the sign
  always_comb begin
    sub  = {1'b0, bus.pixIn} - {1'b0, prev};
    diff = sub[PIX_W] ? PIX_W'(-sub) : sub[PIX_W-1:0];
  end

  assign lineStart = bus.lineReset || (pixCnt == CNT_W'(LINE_LEN));

  always_comb begin
    stateD     = state;
    prevD      = prev;
    pixCntD    = pixCnt;
    edgeCntD   = edgeCnt;
    edgeValidD = 1'b0;
    lineDoneD  = 1'b0;
    edgeIdxD   = edgeIdx;
    edgeMagD   = edgeMag;
    lineEdgesD = lineEdges;

    case (state)
      IDLE: begin
        if (bus.enb) begin
          prevD    = bus.pixIn;
          pixCntD  = CNT_W'(1);
          edgeCntD = '0;
          stateD   = RUN;
        end
      end
      RUN: begin
        if (bus.enb) begin
          prevD = bus.pixIn;
          if (lineStart) begin
            // New line: close out the previous one, never compare across it
            lineDoneD  = 1'b1;
            lineEdgesD = edgeCnt;
            edgeCntD   = '0;
            pixCntD    = CNT_W'(1);
          end else begin
            pixCntD = pixCnt + CNT_W'(1);
            if (diff > bus.threshold) begin
              edgeValidD = 1'b1;
              edgeIdxD   = bus.idxIn;
              edgeMagD   = diff;
              if (edgeCnt != EDGE_MAX) begin
                edgeCntD = edgeCnt + EDGE_W'(1);
              end
            end
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      state     <= IDLE;
      prev      <= '0;
      pixCnt    <= '0;
      edgeCnt   <= '0;
      edgeValid <= 1'b0;
      edgeIdx   <= '0;
      edgeMag   <= '0;
      lineDone  <= 1'b0;
      lineEdges <= '0;
    end else begin
      state     <= stateD;
      prev      <= prevD;
      pixCnt    <= pixCntD;
      edgeCnt   <= edgeCntD;
      edgeValid <= edgeValidD;
      edgeIdx   <= edgeIdxD;
      edgeMag   <= edgeMagD;
      lineDone  <= lineDoneD;
      lineEdges <= lineEdgesD;
    end
  end

  assign bus.edgeValid = edgeValid;
  assign bus.edgeIdx   = edgeIdx;
  assign bus.edgeMag   = edgeMag;
  assign bus.lineDone  = lineDone;
  assign bus.lineEdges = lineEdges;

endmodule
